// File: rtl/alu_if.sv
// alu_if: operand, opcode and result/flag bundle between the datapath and the ALU.
interface alu_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0] F;
  logic [WIDTH-1:0] Y;
  logic Cout;
  logic Oflow;
  logic Zero;
  modport master (output A, B, F, input Y, Cout, Oflow, Zero);
  modport slave (input A, B, F, output Y, Cout, Oflow, Zero);
endinterface

// File: rtl/alu.sv
// alu: MIPS ALU (AND/OR/ADD/SUB/SLT) with a sticky overflow flag; ALU_OUTREG_EN registers Y and the flags.
module alu #(parameter int WIDTH = 32) (
  input  logic clk,
  input  logic ci_rst_n,
  alu_if.slave bus,
  input  logic ciClrOflow,
  output logic doOflowSticky
);
  logic [WIDTH-1:0] bb, y_c;
  logic [WIDTH:0] s;
  logic ovf, oflow_c, cout_c, zero_c, arith;
  assign bb = bus.F[2] ? ~bus.B : bus.B;
  assign s = {1'b0, bus.A} + {1'b0, bb} + {{WIDTH{1'b0}}, bus.F[2]};
  assign ovf = (bus.A[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != bus.A[WIDTH-1]);
  assign arith = bus.F[1:0] == 2'b10;
  // SLT folds overflow back in so the sign compare stays correct across wraparound
  always_comb begin
    y_c = bus.F[1:0] == 2'b00 ? bus.A & bb :
          bus.F[1:0] == 2'b01 ? bus.A | bb :
          bus.F[1:0] == 2'b10 ? s[WIDTH-1:0] :
          bus.F[2] ? {{(WIDTH-1){1'b0}}, s[WIDTH-1] ^ ovf} : '0;
    oflow_c = arith & ovf;
    cout_c = arith & s[WIDTH];
    zero_c = y_c == '0;
  end
  always_ff @(posedge clk or negedge ci_rst_n)
    if (!ci_rst_n) doOflowSticky <= 1'b0;
    else if (oflow_c) doOflowSticky <= 1'b1;
    else if (ciClrOflow) doOflowSticky <= 1'b0;
`ifdef ALU_OUTREG_EN
  always_ff @(posedge clk or negedge ci_rst_n)
    if (!ci_rst_n) begin
      bus.Y <= '0;
      bus.Cout <= 1'b0;
      bus.Oflow <= 1'b0;
      bus.Zero <= 1'b1;
    end else begin
      bus.Y <= y_c;
      bus.Cout <= cout_c;
      bus.Oflow <= oflow_c;
      bus.Zero <= zero_c;
    end
`else
  assign bus.Y = y_c;
  assign bus.Cout = cout_c;
  assign bus.Oflow = oflow_c;
  assign bus.Zero = zero_c;
`endif
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors for alu, combinational or ALU_OUTREG_EN build.
module tb_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic sticky;
  int n_cmp = 0;
  int n_bad = 0;
  alu_if #(.WIDTH(32)) bus ();
  alu #(.WIDTH(32)) dut (
    .clk(clk),
    .ci_rst_n(rst_n),
    .bus(bus.slave),
    .ciClrOflow(clr),
    .doOflowSticky(sticky)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    bus.A = a;
    bus.B = b;
    bus.F = f;
`ifdef ALU_OUTREG_EN
    @(posedge clk);
`endif
    #1;
  endtask
  initial begin
    apply(32'h5, 32'h3, 3'b010);
`ifdef ALU_OUTREG_EN
    check("rst_y", bus.Y, 32'h0);
    check("rst_zero", {31'b0, bus.Zero}, 32'h1);
`else
    check("rst_y", bus.Y, 32'h8);
    check("rst_zero", {31'b0, bus.Zero}, 32'h0);
`endif
    check("rst_sticky", {31'b0, sticky}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    apply(32'h5, 32'h3, 3'b010);
    check("add_y", bus.Y, 32'h8);
    check("add_zero", {31'b0, bus.Zero}, 32'h0);
    check("add_cout", {31'b0, bus.Cout}, 32'h0);
    check("add_oflow", {31'b0, bus.Oflow}, 32'h0);
    apply(32'h5, 32'h3, 3'b110);
    check("sub_y", bus.Y, 32'h2);
    check("sub_cout", {31'b0, bus.Cout}, 32'h1);
    apply(32'h5, 32'h3, 3'b111);
    check("slt_y", bus.Y, 32'h0);
    check("slt_zero", {31'b0, bus.Zero}, 32'h1);
    apply(32'h12345678, 32'h12345678, 3'b110);
    check("beq_y", bus.Y, 32'h0);
    check("beq_zero", {31'b0, bus.Zero}, 32'h1);
    check("beq_cout", {31'b0, bus.Cout}, 32'h1);
    check("beq_oflow", {31'b0, bus.Oflow}, 32'h0);
    apply(32'h80000000, 32'h1, 3'b111);
    check("slt_neg", bus.Y, 32'h1);
    check("slt_neg_zero", {31'b0, bus.Zero}, 32'h0);
    apply(32'h7FFFFFFF, 32'hFFFFFFFF, 3'b111);
    check("slt_ovf", bus.Y, 32'h0);
    check("slt_ovf_oflow", {31'b0, bus.Oflow}, 32'h0);
    apply(32'hF0F0F0F0, 32'h0FF00FF0, 3'b000);
    check("and", bus.Y, 32'h00F000F0);
    apply(32'hF0F0F0F0, 32'h0FF00FF0, 3'b001);
    check("or", bus.Y, 32'hFFF0FFF0);
    apply(32'hF0F0F0F0, 32'h0FF00FF0, 3'b100);
    check("andn", bus.Y, 32'hF000F000);
    apply(32'hF0F0F0F0, 32'h0FF00FF0, 3'b101);
    check("orn", bus.Y, 32'hF0FFF0FF);
    apply(32'hF0F0F0F0, 32'h0FF00FF0, 3'b011);
    check("zero_op", bus.Y, 32'h0);
    check("zero_op_zero", {31'b0, bus.Zero}, 32'h1);
    check("sticky_idle", {31'b0, sticky}, 32'h0);
    apply(32'h7FFFFFFF, 32'h1, 3'b010);
    check("ovf_y", bus.Y, 32'h80000000);
    check("ovf_oflow", {31'b0, bus.Oflow}, 32'h1);
    check("ovf_cout", {31'b0, bus.Cout}, 32'h0);
    @(posedge clk) #1;
    check("sticky_set", {31'b0, sticky}, 32'h1);
    apply(32'h5, 32'h3, 3'b000);
    @(posedge clk) #1;
    check("sticky_hold", {31'b0, sticky}, 32'h1);
    clr = 1'b1;
    @(posedge clk) #1;
    check("sticky_clr", {31'b0, sticky}, 32'h0);
    clr = 1'b0;
    apply(32'h80000000, 32'h1, 3'b110);
    check("subovf_y", bus.Y, 32'h7FFFFFFF);
    check("subovf_oflow", {31'b0, bus.Oflow}, 32'h1);
    check("subovf_cout", {31'b0, bus.Cout}, 32'h1);
    clr = 1'b1;
    @(posedge clk) #1;
    check("sticky_prio", {31'b0, sticky}, 32'h1);
    clr = 1'b0;
    @(negedge clk) #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sticky", {31'b0, sticky}, 32'h0);
`ifdef ALU_OUTREG_EN
    check("mid_rst_y", bus.Y, 32'h0);
    check("mid_rst_zero", {31'b0, bus.Zero}, 32'h1);
`else
    check("mid_rst_y", bus.Y, 32'h7FFFFFFF);
    check("mid_rst_zero", {31'b0, bus.Zero}, 32'h0);
`endif
    @(negedge clk) rst_n = 1'b1;
    apply(32'h5, 32'h3, 3'b010);
    check("lat_base", bus.Y, 32'h8);
    bus.A = 32'h1;
    #1;
`ifdef ALU_OUTREG_EN
    check("lat_hold", bus.Y, 32'h8);
    @(posedge clk) #1;
`endif
    check("lat_new", bus.Y, 32'h4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit ALU for the single-cycle MIPS datapath.
- Implements AND, OR, add, subtract and set-less-than, selected by the 3-bit F code from the control unit's ALU decoder.
- The `Zero` output drives the branch decision (`beq`). `Cout` and `Oflow` are status outputs.
- A clocked sticky-overflow status register records any arithmetic overflow since reset or since the last clear.

Parameters:
- WIDTH, 32, datapath width in bits for A, B and Y (must be ≥2).

Ports:
- clk  input  1  system clock; rising-edge active.
- ci_rst_n  input  1  reset; asynchronous, active-low.
- A  input  WIDTH  operand A (SrcA, register file RD1).
- B  input  WIDTH  operand B (SrcB, register RD2 or sign-extended immediate).
- F  input  3  operation select.
- Y  output  WIDTH  result.
- Cout  output  1  adder carry out.
- Oflow  output  1  signed overflow of add/sub.
- Zero  output  1  high when Y is all zeros.
- ciClrOflow  input  1  synchronous clear of the sticky overflow flag.
- doOflowSticky  output  1  sticky overflow flag.

Behaviour:
- Operand conditioning:
  - Bb = F[2] ? ~B : B.
  - Carry-in = F[2].
  - S = A + Bb + F[2], computed at WIDTH+1 bits.
  - Cout_raw = bit WIDTH of S.
- Y selection by F[1:0]:
  - 00: A & Bb.
  - 01: A | Bb.
  - 10: S[WIDTH-1:0].
  - 11, F[2]=1: {zeros, S[WIDTH-1] ^ ovf}, i.e. correct signed A<B including overflow cases.
  - 11, F[2]=0: Y = 0.
- Resulting codes:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
  - 100 A&~B, 101 A|~B.
  - 011 constant zero.
- ovf = (A[MSB] == Bb[MSB]) && (S[MSB] != A[MSB]).
- Flag outputs:
  - Oflow = ovf when F[1:0]=10, else 0.
  - Cout = Cout_raw when F[1:0]=10, else 0.
  - Zero = (Y == 0), evaluated for every F, including logic ops and SLT.
- Y, Cout, Oflow and Zero are purely combinational: same-cycle, zero latency. They are unaffected by clk and reset (the single-cycle datapath requires this).
- Sticky register doOflowSticky:
  - Async reset to 0 when ci_rst_n=0.
  - At each rising clk edge: sets to 1 if Oflow=1.
  - Else clears to 0 if ciClrOflow=1.
  - Else holds.
  - If Oflow=1 and ciClrOflow=1 in the same cycle, set wins.
- Reset asserted mid-operation clears the sticky flag immediately. Combinational outputs keep tracking A, B and F.
- No X propagation for defined inputs. All 8 F codes are defined.

Optional Feature:
- Macro ALU_OUTREG_EN.
- Defined:
  - Y, Cout, Oflow and Zero are registered on rising clk: 1-cycle latency.
  - Async reset values: Y=0, Cout=0, Oflow=0, Zero=1.
  - doOflowSticky samples the combinational ovf term (gated as Oflow), so it updates on the same edge that registers Oflow.
- Undefined: outputs are combinational as above.

Test Plan:
- A=0x00000005, B=0x00000003: F=010 → Y=0x8, Zero=0, Cout=0, Oflow=0; F=110 → Y=0x2, Cout=1; F=111 → Y=0.
- A=B=0x12345678, F=110 → Y=0, Zero=1, Cout=1, Oflow=0 (beq taken).
- A=0x7FFFFFFF, B=0x00000001, F=010 → Y=0x80000000, Oflow=1, Cout=0. Next clk: doOflowSticky=1. It remains 1 with benign ops until ciClrOflow=1 for one edge, then 0.
- A=0x80000000, B=0x00000001, F=111 → Y=1. A=0x7FFFFFFF, B=0xFFFFFFFF, F=111 → Y=0 (overflow-corrected SLT).
- A=0xF0F0F0F0, B=0x0FF00FF0: F=000 → Y=0x00F000F0; F=001 → Y=0xFFF0FFF0; F=100 → Y=0xF000F000; F=011 → Y=0, Zero=1.
- Sticky reset/priority: drive Oflow=1 and ciClrOflow=1 on the same edge → doOflowSticky=1. Assert ci_rst_n=0 between edges → doOflowSticky=0 immediately. With ALU_OUTREG_EN, the reset state is Y=0, Zero=1, and outputs lag inputs by exactly one edge.
